// File: rtl/serial_pkg.sv
// serial_pkg: shared types and helpers for the serial link (transmitter and receiver).
//   tx_state_t   - frame state encoding used by serial_tx
//   LINE_IDLE    - level of the serial line when no frame is in flight
//   even_parity  - XOR of a word, zero-extended to PARITY_MAX_W bits
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;

  // Widest payload the parity helper handles; callers zero-extend narrower words,
  // which leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// bit_timer: bit-period counter for serial_tx.
//   clk     - clock
//   rst     - synchronous reset, active-high
//   en      - count while high; counter is held at 0 while low
//   bit_end - one-cycle pulse on the last cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_end = en && (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (!en || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter, LSB first.
//   Frame: start(0) | DATA_W data bits | optional even parity | stop(1),
//   each bit held CLKS_PER_BIT cycles.
//   clk      - clock
//   rst      - synchronous reset, active-high (aborts any frame)
//   tx_data  - word to send, captured on the accept edge
//   tx_valid - tx_data is valid
//   tx_ready - high only in IDLE
//   tx_line  - registered serial line, idles at 1
//   tx_busy  - frame in progress
//   tx_done  - one-cycle pulse as the frame completes
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | start bit (0)
// DATA   | data bits, shift_q[0] on the line
// PARITY | even-parity bit of the captured word
// STOP   | stop bit (1)
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_W - 1);

  tx_state_t         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              parity_q, parity_d;
  logic              line_q, line_d;
  logic              done_q, done_d;
  logic              bit_end;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q != IDLE),
    .bit_end(bit_end)
  );

  // line_d is derived from the next state so the registered line changes on
  // the same edge as the state.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    parity_d  = parity_q;
    line_d    = line_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        line_d = LINE_IDLE;
        if (tx_valid) begin
          state_d   = START;
          shift_d   = tx_data;
          parity_d  = even_parity(PARITY_MAX_W'(tx_data));
          bit_idx_d = '0;
          line_d    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              line_d  = parity_q;
            end else begin
              state_d = STOP;
              line_d  = LINE_IDLE;
            end
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + BW'(1);
            line_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          line_d  = LINE_IDLE;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          line_d  = LINE_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = LINE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      parity_q  <= 1'b0;
      line_q    <= LINE_IDLE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      parity_q  <= parity_d;
      line_q    <= line_d;
      done_q    <= done_d;
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_line  = line_q;
  assign tx_done  = done_q;

endmodule
